// File: rtl/nc_sample_sequencer.sv
// nc_sample_sequencer: AXI4-Lite master that writes each accepted audio
// sample into the nc_test sample window at a circular index. It then reads
// the result register back and presents the low 16 bits on a valid/ready
// stream.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARESETN  clock, asynchronous active-low reset
//   SMP_IN_*                    sample input stream (16-bit signed)
//   RES_OUT_*                   filtered result stream (16-bit)
//   ERR_COUNT                   saturating count of non-OKAY B/R responses
//   M_AXI_*                     AXI4-Lite master (one transaction in flight)
module nc_sample_sequencer #(
  parameter logic [31:0] C_BASEADDR      = 32'h7a80_0000,
  parameter logic [31:0] C_SAMPLE_OFFSET = 32'h0000_0100,
  parameter logic [31:0] C_RESULT_OFFSET = 32'h0000_0000,
  parameter int unsigned C_MEM_WORDS     = 64
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic [15:0] SMP_IN_DATA,
  input  logic        SMP_IN_VALID,
  output logic        SMP_IN_READY,
  output logic [15:0] RES_OUT_DATA,
  output logic        RES_OUT_VALID,
  input  logic        RES_OUT_READY,
  output logic [7:0]  ERR_COUNT,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam int unsigned IDX_W       = (C_MEM_WORDS > 1) ? $clog2(C_MEM_WORDS) : 1;
  localparam logic [31:0] SAMPLE_BASE = C_BASEADDR + C_SAMPLE_OFFSET;
  localparam logic [31:0] RESULT_ADDR = C_BASEADDR + C_RESULT_OFFSET;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_WRESP, ST_READ, ST_RDATA, ST_OUTPUT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;

  logic accept_c;
  logic aw_done_c;
  logic w_done_c;
  logic b_ok_c;
  logic b_err_c;
  logic r_ok_c;
  logic r_err_c;
  logic unused_rdata_hi;

  // SMP_IN_READY is only high in IDLE (and low in the first cycle out of reset)
  assign accept_c  = SMP_IN_READY && SMP_IN_VALID;
  // A channel is done once its VALID has dropped or it handshakes this cycle
  assign aw_done_c = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done_c  = !M_AXI_WVALID  || M_AXI_WREADY;
  assign b_ok_c    = (state == ST_WRESP) && M_AXI_BVALID && (M_AXI_BRESP == 2'b00);
  assign b_err_c   = (state == ST_WRESP) && M_AXI_BVALID && (M_AXI_BRESP != 2'b00);
  assign r_ok_c    = (state == ST_RDATA) && M_AXI_RVALID && (M_AXI_RRESP == 2'b00);
  assign r_err_c   = (state == ST_RDATA) && M_AXI_RVALID && (M_AXI_RRESP != 2'b00);

  assign M_AXI_WSTRB     = 4'hF;
  assign unused_rdata_hi = ^M_AXI_RDATA[31:16];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept_c) state_nxt = ST_WRITE;
      ST_WRITE:  if (aw_done_c && w_done_c) state_nxt = ST_WRESP;
      ST_WRESP:  if (M_AXI_BVALID) state_nxt = b_ok_c ? ST_READ : ST_IDLE;
      ST_READ:   if (M_AXI_ARREADY) state_nxt = ST_RDATA;
      ST_RDATA:  if (M_AXI_RVALID) state_nxt = r_ok_c ? ST_OUTPUT : ST_IDLE;
      ST_OUTPUT: if (RES_OUT_READY) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State, index, error counter and registered outputs
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= ST_IDLE;
      idx           <= '0;
      ERR_COUNT     <= 8'd0;
      SMP_IN_READY  <= 1'b0;
      RES_OUT_VALID <= 1'b0;
      RES_OUT_DATA  <= 16'd0;
      M_AXI_AWADDR  <= 32'd0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= 32'd0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= 32'd0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      state         <= state_nxt;
      SMP_IN_READY  <= (state_nxt == ST_IDLE);
      M_AXI_BREADY  <= (state_nxt == ST_WRESP);
      M_AXI_ARVALID <= (state_nxt == ST_READ);
      M_AXI_RREADY  <= (state_nxt == ST_RDATA);
      RES_OUT_VALID <= (state_nxt == ST_OUTPUT);

      // AW and W rise together; each drops on its own handshake
      if (accept_c) begin
        M_AXI_AWVALID <= 1'b1;
        M_AXI_WVALID  <= 1'b1;
        M_AXI_AWADDR  <= SAMPLE_BASE + (32'(idx) << 2);
        M_AXI_WDATA   <= {{16{SMP_IN_DATA[15]}}, SMP_IN_DATA};
      end else begin
        if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
        if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
      end

      // Index only advances on a successful write; wraps as a power of two
      if (b_ok_c) begin
        idx          <= idx + IDX_W'(1);
        M_AXI_ARADDR <= RESULT_ADDR;
      end

      if (r_ok_c) RES_OUT_DATA <= M_AXI_RDATA[15:0];

      if ((b_err_c || r_err_c) && (ERR_COUNT != 8'hFF)) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_nc_sample_sequencer.sv
// Directed testbench for nc_sample_sequencer with a behavioural AXI4-Lite slave.
module tb_nc_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] SMP_IN_DATA;
  logic        SMP_IN_VALID;
  logic        SMP_IN_READY;
  logic [15:0] RES_OUT_DATA;
  logic        RES_OUT_VALID;
  logic        RES_OUT_READY;
  logic [7:0]  ERR_COUNT;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  int vectors     = 0;
  int miscompares = 0;

  // Slave configuration
  int          aw_lat = 0;
  int          w_lat  = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0000_1234;

  // Slave bookkeeping
  bit          aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_got, w_got;
  bit          bready_prev, aw_prev_v, w_prev_v, ar_prev_v;
  logic [31:0] aw_prev_a, w_prev_d, ar_prev_a, last_awaddr, last_wdata;
  int          aw_cnt, w_cnt, cyc, aw_hs, w_hs, ar_hs;
  int          aw_fire_cyc, w_fire_cyc, b_rise_cyc, unstable;

  always #5 clk = ~clk;

  nc_sample_sequencer dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .SMP_IN_DATA   (SMP_IN_DATA),
    .SMP_IN_VALID  (SMP_IN_VALID),
    .SMP_IN_READY  (SMP_IN_READY),
    .RES_OUT_DATA  (RES_OUT_DATA),
    .RES_OUT_VALID (RES_OUT_VALID),
    .RES_OUT_READY (RES_OUT_READY),
    .ERR_COUNT     (ERR_COUNT),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  task automatic slave_clear();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    M_AXI_BVALID  = 1'b0; M_AXI_BRESP  = 2'b00;
    M_AXI_RVALID  = 1'b0; M_AXI_RRESP  = 2'b00; M_AXI_RDATA = 32'd0;
    aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
    aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
    bready_prev = 0; aw_prev_v = 0; w_prev_v = 0; ar_prev_v = 0;
  endtask

  // Behavioural slave: decides at each falling edge what handshakes occur on
  // the next rising edge; B and R answer one cycle after their request.
  initial begin : slave
    cyc = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; unstable = 0;
    aw_fire_cyc = 0; w_fire_cyc = 0; b_rise_cyc = 0;
    aw_prev_a = 0; w_prev_d = 0; ar_prev_a = 0; last_awaddr = 0; last_wdata = 0;
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slave_clear();
      end else begin
        cyc++;
        if (aw_fire) aw_got = 1;
        if (w_fire)  w_got  = 1;
        if (b_fire)  M_AXI_BVALID = 1'b0;
        if (r_fire)  M_AXI_RVALID = 1'b0;
        if (aw_got && w_got) begin
          M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp_cfg; aw_got = 0; w_got = 0;
        end
        if (ar_fire) begin
          M_AXI_RVALID = 1'b1; M_AXI_RRESP = rresp_cfg; M_AXI_RDATA = rdata_cfg;
        end
        if (M_AXI_AWVALID && aw_prev_v && M_AXI_AWADDR !== aw_prev_a) unstable++;
        if (M_AXI_WVALID  && w_prev_v  && M_AXI_WDATA  !== w_prev_d)  unstable++;
        if (M_AXI_ARVALID && ar_prev_v && M_AXI_ARADDR !== ar_prev_a) unstable++;
        aw_prev_v = M_AXI_AWVALID; aw_prev_a = M_AXI_AWADDR;
        w_prev_v  = M_AXI_WVALID;  w_prev_d  = M_AXI_WDATA;
        ar_prev_v = M_AXI_ARVALID; ar_prev_a = M_AXI_ARADDR;
        if (M_AXI_BREADY && !bready_prev) b_rise_cyc = cyc;
        bready_prev = M_AXI_BREADY;
        if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_lat); aw_cnt++; end
        else begin M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
        if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_lat); w_cnt++; end
        else begin M_AXI_WREADY = 1'b0; w_cnt = 0; end
        M_AXI_ARREADY = M_AXI_ARVALID;
        aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
        w_fire  = M_AXI_WVALID  && M_AXI_WREADY;
        ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
        b_fire  = M_AXI_BVALID  && M_AXI_BREADY;
        r_fire  = M_AXI_RVALID  && M_AXI_RREADY;
        if (aw_fire) begin aw_hs++; last_awaddr = M_AXI_AWADDR; aw_fire_cyc = cyc; end
        if (w_fire)  begin w_hs++;  last_wdata  = M_AXI_WDATA;  w_fire_cyc  = cyc; end
        if (ar_fire) ar_hs++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    slave_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sends one sample and waits until the sequencer is back in IDLE
  task automatic process_sample(input logic [15:0] s, output logic [31:0] aw,
                                output logic [31:0] wd, output bit got_res,
                                output logic [15:0] res);
    int n;
    got_res = 0; res = 16'd0;
    n = 0;
    while (!SMP_IN_READY && n < 100) begin tick(); n++; end
    SMP_IN_DATA = s; SMP_IN_VALID = 1'b1;
    tick();
    SMP_IN_VALID = 1'b0;
    n = 0;
    while (!SMP_IN_READY && n < 100) begin
      if (RES_OUT_VALID && RES_OUT_READY) begin got_res = 1; res = RES_OUT_DATA; end
      tick(); n++;
    end
    vectors++;
    if (!SMP_IN_READY) begin
      miscompares++;
      $display("FAIL sample_timeout: SMP_IN_READY=%b after 100 cycles, required 1", SMP_IN_READY);
    end
    aw = last_awaddr; wd = last_wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SMP_IN_VALID = 1'b0; SMP_IN_DATA = 16'd0; RES_OUT_READY = 1'b1;
    slave_clear();
    tick(); tick();
    vectors++;
    if ({SMP_IN_READY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
         M_AXI_RREADY, RES_OUT_VALID} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_handshakes: got %b required 0000000",
               {SMP_IN_READY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                M_AXI_ARVALID, M_AXI_RREADY, RES_OUT_VALID});
    end
    vectors++;
    if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, RES_OUT_DATA, ERR_COUNT} !== 120'd0) begin
      miscompares++;
      $display("FAIL reset_data: aw=%h wd=%h ar=%h res=%h err=%0d, required all zero",
               M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, RES_OUT_DATA, ERR_COUNT);
    end
    vectors++;
    if (M_AXI_WSTRB !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_wstrb: got %h required f", M_AXI_WSTRB);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (SMP_IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ready: got %b required 1", SMP_IN_READY);
    end
  endtask

  task automatic test_single();
    rdata_cfg = 32'h0000_1234;
    SMP_IN_DATA = 16'h8001; SMP_IN_VALID = 1'b1;
    tick();
    SMP_IN_VALID = 1'b0;
    vectors++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR, M_AXI_WDATA} !== {2'b11, 32'h7a80_0100, 32'hffff_8001}) begin
      miscompares++;
      $display("FAIL single_write: v=%b aw=%h wd=%h required v=11 aw=7a800100 wd=ffff8001",
               {M_AXI_AWVALID, M_AXI_WVALID}, M_AXI_AWADDR, M_AXI_WDATA);
    end
    tick();
    vectors++;
    if ({M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID} !== 3'b100) begin
      miscompares++;
      $display("FAIL single_wresp: bready/awv/wv=%b required 100",
               {M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID});
    end
    tick();
    vectors++;
    if ({M_AXI_ARVALID, M_AXI_ARADDR} !== {1'b1, 32'h7a80_0000}) begin
      miscompares++;
      $display("FAIL single_read: arvalid=%b araddr=%h required 1 7a800000", M_AXI_ARVALID, M_AXI_ARADDR);
    end
    tick();
    vectors++;
    if ({M_AXI_RREADY, RES_OUT_VALID} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_rdata: rready/resvalid=%b required 10", {M_AXI_RREADY, RES_OUT_VALID});
    end
    tick();
    vectors++;
    if ({RES_OUT_VALID, RES_OUT_DATA} !== {1'b1, 16'h1234}) begin
      miscompares++;
      $display("FAIL single_result: valid=%b data=%h required 1 1234", RES_OUT_VALID, RES_OUT_DATA);
    end
    tick();
    vectors++;
    if ({SMP_IN_READY, RES_OUT_VALID} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_idle: smp_ready/resvalid=%b required 10", {SMP_IN_READY, RES_OUT_VALID});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] aw, wd, exp_aw, exp_wd;
    logic [15:0] s, res;
    bit          got;
    do_reset();
    for (int i = 0; i < 65; i++) begin
      s = 16'h7ff0 + 16'(i);
      rdata_cfg = 32'(i) ^ 32'h0000_5a00;
      process_sample(s, aw, wd, got, res);
      exp_aw = 32'h7a80_0100 + 32'(4 * (i % 64));
      exp_wd = 32'($signed(s));
      vectors++;
      if ({aw, wd, got, res} !== {exp_aw, exp_wd, 1'b1, rdata_cfg[15:0]}) begin
        miscompares++;
        $display("FAIL wrap_%0d: aw=%h wd=%h res=%b/%h required aw=%h wd=%h res=1/%h",
                 i, aw, wd, got, res, exp_aw, exp_wd, rdata_cfg[15:0]);
      end
    end
  endtask

  task automatic test_aw_w_order();
    logic [31:0] aw, wd;
    logic [15:0] res;
    bit          got;
    int          aw0, w0, later;
    for (int pass = 0; pass < 2; pass++) begin
      aw_lat = (pass == 0) ? 3 : 0;
      w_lat  = (pass == 0) ? 0 : 3;
      aw0 = aw_hs; w0 = w_hs; unstable = 0;
      process_sample(16'h1357, aw, wd, got, res);
      later = (aw_fire_cyc > w_fire_cyc) ? aw_fire_cyc : w_fire_cyc;
      vectors++;
      if ({aw_hs - aw0, w_hs - w0} !== {32'd1, 32'd1}) begin
        miscompares++;
        $display("FAIL order_%0d_handshakes: aw=%0d w=%0d required 1 1", pass, aw_hs - aw0, w_hs - w0);
      end
      vectors++;
      if (b_rise_cyc !== later + 1) begin
        miscompares++;
        $display("FAIL order_%0d_wresp: bready rose at %0d required %0d", pass, b_rise_cyc, later + 1);
      end
      vectors++;
      if ({unstable, wd, got} !== {32'd0, 32'h0000_1357, 1'b1}) begin
        miscompares++;
        $display("FAIL order_%0d_stable: unstable=%0d wd=%h res=%b required 0 00001357 1",
                 pass, unstable, wd, got);
      end
      if (wd !== 32'h0000_1357) $display("FAIL order_%0d_wdata: got %h required 00001357", pass, wd);
    end
    aw_lat = 0; w_lat = 0;
  endtask

  task automatic test_resp_errors();
    logic [31:0] aw, wd;
    logic [15:0] res;
    bit          got;
    int          ar0;
    do_reset();
    rdata_cfg = 32'h0000_4321;
    for (int i = 0; i < 4; i++) process_sample(16'(i), aw, wd, got, res);
    bresp_cfg = 2'b10; ar0 = ar_hs;
    process_sample(16'h0005, aw, wd, got, res);
    vectors++;
    if ({ERR_COUNT, ar_hs - ar0, got, aw} !== {8'd1, 32'd0, 1'b0, 32'h7a80_0110}) begin
      miscompares++;
      $display("FAIL bresp_err: err=%0d ar=%0d res=%b aw=%h required 1 0 0 7a800110",
               ERR_COUNT, ar_hs - ar0, got, aw);
    end
    bresp_cfg = 2'b00;
    process_sample(16'h0006, aw, wd, got, res);
    vectors++;
    if ({aw, got, res} !== {32'h7a80_0110, 1'b1, 16'h4321}) begin
      miscompares++;
      $display("FAIL bresp_reuse: aw=%h res=%b/%h required 7a800110 1/4321", aw, got, res);
    end
    rresp_cfg = 2'b10; ar0 = ar_hs;
    process_sample(16'h0007, aw, wd, got, res);
    vectors++;
    if ({ERR_COUNT, ar_hs - ar0, got, aw} !== {8'd2, 32'd1, 1'b0, 32'h7a80_0114}) begin
      miscompares++;
      $display("FAIL rresp_err: err=%0d ar=%0d res=%b aw=%h required 2 1 0 7a800114",
               ERR_COUNT, ar_hs - ar0, got, aw);
    end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_backpressure();
    int n;
    RES_OUT_READY = 1'b0;
    rdata_cfg = 32'hffff_beef;
    SMP_IN_DATA = 16'h0042; SMP_IN_VALID = 1'b1;
    tick();
    SMP_IN_VALID = 1'b0;
    n = 0;
    while (!RES_OUT_VALID && n < 20) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({RES_OUT_VALID, RES_OUT_DATA, SMP_IN_READY} !== {1'b1, 16'hbeef, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_%0d: valid=%b data=%h smp_ready=%b required 1 beef 0",
                 i, RES_OUT_VALID, RES_OUT_DATA, SMP_IN_READY);
      end
      tick();
    end
    RES_OUT_READY = 1'b1;
    tick();
    vectors++;
    if ({RES_OUT_VALID, SMP_IN_READY} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_release: valid/smp_ready=%b required 01", {RES_OUT_VALID, SMP_IN_READY});
    end
  endtask

  task automatic test_err_saturate();
    logic [31:0] aw, wd;
    logic [15:0] res;
    bit          got;
    do_reset();
    bresp_cfg = 2'b10;
    for (int i = 0; i < 300; i++) begin
      process_sample(16'(i), aw, wd, got, res);
      if (i == 253) begin
        vectors++;
        if (ERR_COUNT !== 8'd254) begin
          miscompares++;
          $display("FAIL err_254: got %0d required 254", ERR_COUNT);
        end
      end
    end
    vectors++;
    if ({ERR_COUNT, got} !== {8'd255, 1'b0}) begin
      miscompares++;
      $display("FAIL err_sat: err=%0d res=%b required 255 0", ERR_COUNT, got);
    end
    bresp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [31:0] aw, wd;
    logic [15:0] res;
    bit          got;
    rdata_cfg = 32'h0000_0abc;
    process_sample(16'h0001, aw, wd, got, res);
    process_sample(16'h0002, aw, wd, got, res);
    SMP_IN_DATA = 16'h0003; SMP_IN_VALID = 1'b1;
    tick();
    SMP_IN_VALID = 1'b0;
    repeat (3) tick();
    vectors++;
    if (M_AXI_RREADY !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_in_rdata: rready=%b required 1", M_AXI_RREADY);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({SMP_IN_READY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
         M_AXI_RREADY, RES_OUT_VALID, ERR_COUNT} !== 15'd0) begin
      miscompares++;
      $display("FAIL mid_async: handshakes=%b err=%0d required 0000000 0",
               {SMP_IN_READY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                M_AXI_ARVALID, M_AXI_RREADY, RES_OUT_VALID}, ERR_COUNT);
    end
    slave_clear();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({SMP_IN_READY, ERR_COUNT} !== {1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL mid_release: smp_ready=%b err=%0d required 1 0", SMP_IN_READY, ERR_COUNT);
    end
    process_sample(16'h0004, aw, wd, got, res);
    vectors++;
    if ({aw, got, res} !== {32'h7a80_0100, 1'b1, 16'h0abc}) begin
      miscompares++;
      $display("FAIL mid_idx0: aw=%h res=%b/%h required 7a800100 1/0abc", aw, got, res);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_wrap();
    test_aw_w_order();
    test_resp_errors();
    test_backpressure();
    test_err_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nc_sample_sequencer.md
# nc_sample_sequencer

AXI4-Lite master that feeds audio samples into the nc_test noise-cancelling peripheral and collects its filtered output. Each accepted input sample is written into the peripheral's sample memory window at a circular index. The result register is then read back and presented on a valid/ready output stream. The block sits between the audio capture path and the nc_test slave port, replacing CPU-driven polling for the per-sample datapath.

## Interface
- C_BASEADDR, 32'h7a800000, base address of the nc_test slave
- C_SAMPLE_OFFSET, 32'h00000100, byte offset of the sample memory window
- C_RESULT_OFFSET, 32'h00000000, byte offset of the result register
- C_MEM_WORDS, 64, number of 32-bit words in the circular sample window (power of two, 2..64)

- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- SMP_IN_DATA  in  16  signed input sample
- SMP_IN_VALID  in  1  input sample valid
- SMP_IN_READY  out  1  sequencer can accept a sample
- RES_OUT_DATA  out  16  filtered result, RDATA[15:0]
- RES_OUT_VALID  out  1  result valid
- RES_OUT_READY  in  1  downstream accepts result
- ERR_COUNT  out  8  saturating count of non-OKAY responses
- M_AXI_AWADDR  out  32  write address
- M_AXI_AWVALID  out  1  write address valid
- M_AXI_AWREADY  in  1  write address ready
- M_AXI_WDATA  out  32  write data, sign-extended sample
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WVALID  out  1  write data valid
- M_AXI_WREADY  in  1  write data ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  write response valid
- M_AXI_BREADY  out  1  write response ready
- M_AXI_ARADDR  out  32  read address
- M_AXI_ARVALID  out  1  read address valid
- M_AXI_ARREADY  in  1  read address ready
- M_AXI_RDATA  in  32  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RVALID  in  1  read data valid
- M_AXI_RREADY  out  1  read data ready

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, OUTPUT. One AXI transaction is outstanding at a time.
- IDLE: SMP_IN_READY=1. On SMP_IN_VALID, latch the sample and go to WRITE.
- WRITE:
  - AWVALID and WVALID rise together.
  - AWADDR = C_BASEADDR + C_SAMPLE_OFFSET + 4*idx.
  - WDATA = {{16{s[15]}}, s}.
  - Each VALID drops independently on its own handshake; AW and W may complete in either order or in the same cycle.
  - When both are done, go to WRESP.
- WRESP: BREADY=1. On BVALID:
  - BRESP=00: idx ← (idx+1) mod C_MEM_WORDS, go to READ.
  - Otherwise: ERR_COUNT+1, idx unchanged, go to IDLE. No read is issued and no result is produced.
- READ: ARVALID=1, ARADDR = C_BASEADDR + C_RESULT_OFFSET. On ARREADY, go to RDATA.
- RDATA: RREADY=1. On RVALID:
  - RRESP=00: latch RDATA[15:0], go to OUTPUT.
  - Otherwise: ERR_COUNT+1, go to IDLE.
- OUTPUT: RES_OUT_VALID=1, data held stable until RES_OUT_READY, then go to IDLE.
- ERR_COUNT saturates at 255.
- All AXI outputs, RES_OUT_DATA and the state are registered. AWADDR, WDATA and ARADDR are held stable while the corresponding VALID is high.

## Timing
- Reset values: state=IDLE, idx=0, ERR_COUNT=0, all VALID and READY outputs 0, RES_OUT_DATA=0, addresses and WDATA=0, WSTRB=4'hF. SMP_IN_READY=0 while reset is asserted and 1 in the first cycle after deassertion.
- Each state transition takes one clock after the enabling handshake.
- With a zero-wait slave (AWREADY, WREADY, ARREADY high; BVALID and RVALID one cycle after their request), the sample is accepted at cycle 0:
  - AW/W handshake at cycle 1
  - B at cycle 2
  - AR at cycle 3
  - R at cycle 4
  - RES_OUT_VALID at cycle 5
  - If RES_OUT_READY is high, SMP_IN_READY is back at cycle 6.
- No combinational paths from any input to any output.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously. The pending transaction is abandoned; the slave shares the same reset.
- idx wrap: the write after index C_MEM_WORDS-1 targets index 0.

## Test plan
- Single sample 16'h8001, zero-wait slave returns RDATA 32'h00001234 → AWADDR 32'h7a800100, WDATA 32'hffff8001, ARADDR 32'h7a800000, RES_OUT_DATA 16'h1234 at cycle 5.
- 65 consecutive samples → write addresses step by 4 from 0x7a800100 to 0x7a8001fc, then the 65th write goes to 0x7a800100.
- Slave asserts WREADY 3 cycles before AWREADY, and separately AWREADY before WREADY → exactly one AW and one W handshake, WRESP entered after the later one, addresses and data stable throughout.
- BRESP=2'b10 on sample 5 → ERR_COUNT=1, no AR issued, idx unchanged; the next sample reuses the same address. RRESP=2'b10 → ERR_COUNT increments and no RES_OUT_VALID.
- RES_OUT_READY held low 10 cycles → RES_OUT_VALID and data stable, SMP_IN_READY=0 throughout. 300 forced errors → ERR_COUNT=255.
- M_AXI_ARESETN pulsed low during RDATA → all VALIDs drop immediately; after release idx=0, ERR_COUNT=0, SMP_IN_READY=1.
